// File: rtl/cache_controller_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
// The data and tag memories that sit beside the controller use the same request/entry types.
package cache_controller_pkg;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 10;
  localparam int OFFS_W  = 4;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;
  localparam int LINE_W  = 128;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_req_type;

  typedef logic [LINE_W-1:0] cache_data_type;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } state_type;

endpackage

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache control FSM. Clears the tag memory after reset,
// then serves CPU word requests, writing back dirty victims and refilling lines from main memory.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [31:0]         cpu_req_data,
  output logic                cpu_res_valid,
  output logic [31:0]         cpu_res_data,
  output cache_req_type       data_req,
  output cache_data_type      data_write,
  input  cache_data_type      data_read,
  output cache_req_type       tag_req,
  output cache_tag_type       tag_write,
  input  cache_tag_type       tag_read,
  output logic                mem_req_valid,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output cache_data_type      mem_req_data,
  input  logic                mem_ready,
  input  cache_data_type      mem_rdata
);

  state_type            state, state_next;
  logic [INDEX_W-1:0]   init_cnt;
  logic                 req_rw;
  logic [ADDR_W-1:0]    req_addr;
  logic [31:0]          req_data;
  logic [TAG_W-1:0]     victim_tag;
  cache_data_type       victim_line;

  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [6:0]           word_lsb;
  logic                 hit;
  logic                 unused_addr_bits;

  assign req_index        = req_addr[OFFS_W +: INDEX_W];
  assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
  assign word_lsb         = {req_addr[OFFS_W-1:2], 5'd0};
  assign hit              = tag_read.valid && (tag_read.tag == req_tag);
  assign unused_addr_bits = ^req_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      req_rw      <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      victim_tag  <= '0;
      victim_line <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (state == IDLE && cpu_req_valid) begin
        req_rw   <= cpu_req_rw;
        req_addr <= cpu_req_addr;
        req_data <= cpu_req_data;
      end
      // The victim is captured on the miss so write-back does not depend on the memories holding still.
      if (state == COMPARE && !hit) begin
        victim_tag  <= tag_read.tag;
        victim_line <= data_read;
      end
    end
  end

  always_comb begin
    state_next       = state;
    cpu_req_ready    = 1'b0;
    cpu_res_valid    = 1'b0;
    cpu_res_data     = '0;
    data_req.index   = req_index;
    data_req.we      = 1'b0;
    data_write       = '0;
    tag_req.index    = req_index;
    tag_req.we       = 1'b0;
    tag_write        = '0;
    mem_req_valid    = 1'b0;
    mem_req_rw       = 1'b0;
    mem_req_addr     = '0;
    mem_req_data     = '0;

    case (state)
      INIT: begin
        // Gating with rst_n keeps the tag write enable low while reset is still held.
        tag_req.index = init_cnt;
        tag_req.we    = rst_n;
        if (init_cnt == {INDEX_W{1'b1}}) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          state_next = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          cpu_res_valid = 1'b1;
          state_next    = IDLE;
          if (req_rw) begin
            data_write                = data_read;
            data_write[word_lsb +: 32] = req_data;
            data_req.we               = 1'b1;
            tag_write                 = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            tag_req.we                = 1'b1;
          end else begin
            cpu_res_data = data_read[word_lsb +: 32];
          end
        end else if (tag_read.valid && tag_read.dirty) begin
          state_next = WRITE_BACK;
        end else begin
          state_next = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_tag, req_index, {OFFS_W{1'b0}}};
        mem_req_data  = victim_line;
        if (mem_ready) begin
          state_next = ALLOCATE;
        end
      end

      ALLOCATE: begin
        // After the refill COMPARE re-runs and hits, so a write lands through the normal hit path.
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, {OFFS_W{1'b0}}};
        if (mem_ready) begin
          data_write  = mem_rdata;
          data_req.we = 1'b1;
          tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          tag_req.we  = 1'b1;
          state_next  = COMPARE;
        end
      end

      default: state_next = INIT;
    endcase
  end

endmodule
